// File: rtl/neander_ctrl.sv
// ============================================================================
// neander_ctrl -- Moore control unit for the Neander 8-bit accumulator CPU.
//
// Sequences fetch (F0..F2), decode (DEC) and execute (XN, SK, A0..A2, B1, B2)
// and drives every datapath load/select strobe. Outputs are registered and
// are a function of the registered state only.
//
// Parameters:
//   MEM_LAT    memory read latency in cycles of mem_rd (legal 1..4)
//
// Optional feature (compile-time macro):
//   NEANDER_CTRL_ILLEGAL_TRAP_EN
//     defined   : opcodes 0111, 1011..1110 halt the CPU and set sticky illegal
//     undefined : those opcodes behave as NOP, illegal is constant 0
//
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start              pulse; leaves IDLE/HALT and starts fetching at PC
//   opcode, n, z       RI opcode and NZ flags, sampled only in DEC
//   load_rem, sel_rem  REM load; source 0=PC, 1=memory data
//   inc_pc, load_pc    PC increment / PC <= memory data
//   mem_rd, mem_wr     memory read / write strobes
//   load_ri            RI <= memory data
//   load_ac, load_nz   AC <= ALU result, NZ <= ALU flags
//   ula_op             000 pass, 001 ADD, 010 OR, 011 AND, 100 NOT
//   halted, illegal    HALT indicator, sticky illegal-opcode flag
//   dbg_state          current FSM state encoding (observation only)
//
// Handshake: there is no valid/ready pair; start is a one-cycle request that
// is honoured only in IDLE or HALT and silently dropped in every other state.
// ============================================================================
module neander_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] opcode,
    input  logic       n,
    input  logic       z,
    output logic       load_rem,
    output logic       sel_rem,
    output logic       inc_pc,
    output logic       load_pc,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       load_ri,
    output logic       load_ac,
    output logic       load_nz,
    output logic [2:0] ula_op,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F0   = 4'd1,
        S_F1   = 4'd2,
        S_F2   = 4'd3,
        S_DEC  = 4'd4,
        S_XN   = 4'd5,
        S_SK   = 4'd6,
        S_A0   = 4'd7,
        S_A1   = 4'd8,
        S_A2   = 4'd9,
        S_B1   = 4'd10,
        S_B2   = 4'd11,
        S_HALT = 4'd12
    } state_t;

    typedef struct packed {
        logic       load_rem;
        logic       sel_rem;
        logic       inc_pc;
        logic       load_pc;
        logic       mem_rd;
        logic       mem_wr;
        logic       load_ri;
        logic       load_ac;
        logic       load_nz;
        logic [2:0] ula_op;
        logic       halted;
    } ctrl_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JN  = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Wait-counter value of the final cycle of a memory read.
    localparam logic [1:0] LAST = 2'(MEM_LAT - 1);

    state_t     state, state_n;
    logic [1:0] cnt, cnt_n;
    logic [3:0] op_q, op_n;      // opcode captured in DEC for A2/B1/B2
    logic       illegal_q, illegal_n;
    ctrl_t      ctrl_q;

    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JN) || (op == OP_JZ);
    endfunction

    // Strobes belonging to a given state; registered one cycle ahead so the
    // outputs line up exactly with the state they describe.
    function automatic ctrl_t decode(input state_t s, input logic [1:0] c,
                                     input logic [3:0] op);
        ctrl_t o;
        o = '0;
        case (s)
            S_F0, S_A0: o.load_rem = 1'b1;
            S_F1, S_A1: begin
                o.mem_rd = 1'b1;
                o.inc_pc = (c == LAST);
            end
            S_F2: o.load_ri = 1'b1;
            S_XN: begin
                o.ula_op  = 3'b100;
                o.load_ac = 1'b1;
                o.load_nz = 1'b1;
            end
            S_SK: o.inc_pc = 1'b1;
            S_A2: begin
                if (is_jump(op)) begin
                    o.load_pc = 1'b1;
                end else begin
                    o.load_rem = 1'b1;
                    o.sel_rem  = 1'b1;
                end
            end
            S_B1: begin
                if (op == OP_STA) o.mem_wr = 1'b1;
                else              o.mem_rd = 1'b1;
            end
            S_B2: begin
                o.load_ac = 1'b1;
                o.load_nz = 1'b1;
                case (op)
                    OP_ADD:  o.ula_op = 3'b001;
                    OP_OR:   o.ula_op = 3'b010;
                    OP_AND:  o.ula_op = 3'b011;
                    default: o.ula_op = 3'b000;
                endcase
            end
            S_HALT: o.halted = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 2'd1;
        op_n      = op_q;
        illegal_n = illegal_q;
        case (state)
            S_IDLE: if (start) state_n = S_F0;
            S_HALT: if (start) begin
                state_n   = S_F0;
                illegal_n = 1'b0;
            end
            S_F0: begin
                state_n = S_F1;
                cnt_n   = 2'd0;
            end
            S_F1: if (cnt == LAST) state_n = S_F2;
            S_F2: state_n = S_DEC;
            S_DEC: begin
                op_n = opcode;
                case (opcode)
                    OP_NOP: state_n = S_F0;
                    OP_NOT: state_n = S_XN;
                    OP_HLT: state_n = S_HALT;
                    OP_JN:  state_n = n ? S_A0 : S_SK;
                    OP_JZ:  state_n = z ? S_A0 : S_SK;
                    OP_STA, OP_LDA, OP_ADD, OP_OR, OP_AND, OP_JMP:
                            state_n = S_A0;
                    default: begin
`ifdef NEANDER_CTRL_ILLEGAL_TRAP_EN
                        state_n   = S_HALT;
                        illegal_n = 1'b1;
`else
                        state_n = S_F0;
`endif
                    end
                endcase
            end
            S_XN, S_SK: state_n = S_F0;
            S_A0: begin
                state_n = S_A1;
                cnt_n   = 2'd0;
            end
            S_A1: if (cnt == LAST) state_n = S_A2;
            S_A2: begin
                if (is_jump(op_q)) begin
                    state_n = S_F0;
                end else begin
                    state_n = S_B1;
                    cnt_n   = 2'd0;
                end
            end
            S_B1: begin
                if (op_q == OP_STA)   state_n = S_F0;
                else if (cnt == LAST) state_n = S_B2;
            end
            S_B2: state_n = S_F0;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            op_q      <= 4'd0;
            illegal_q <= 1'b0;
            ctrl_q    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            op_q      <= op_n;
            illegal_q <= illegal_n;
            ctrl_q    <= decode(state_n, cnt_n, op_n);
        end
    end

    assign load_rem  = ctrl_q.load_rem;
    assign sel_rem   = ctrl_q.sel_rem;
    assign inc_pc    = ctrl_q.inc_pc;
    assign load_pc   = ctrl_q.load_pc;
    assign mem_rd    = ctrl_q.mem_rd;
    assign mem_wr    = ctrl_q.mem_wr;
    assign load_ri   = ctrl_q.load_ri;
    assign load_ac   = ctrl_q.load_ac;
    assign load_nz   = ctrl_q.load_nz;
    assign ula_op    = ctrl_q.ula_op;
    assign halted    = ctrl_q.halted;
    assign illegal   = illegal_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_neander_ctrl.sv
// ============================================================================
// tb_neander_ctrl -- bench for neander_ctrl.
// Instance a uses MEM_LAT=1, instance b uses MEM_LAT=3. For each instruction
// the expected per-cycle strobe vector is queued, then the cycles are run and
// each vector popped and compared. opcode/n/z carry the real value only in
// the DEC cycle and random values elsewhere; start is random wherever it must
// be ignored.
// ============================================================================
module tb_neander_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Vector order: load_rem sel_rem inc_pc load_pc mem_rd mem_wr load_ri
    //               load_ac load_nz ula_op[2:0] halted illegal
    localparam logic [13:0] V_LREM = 14'h2000;
    localparam logic [13:0] V_SREM = 14'h1000;
    localparam logic [13:0] V_INC  = 14'h0800;
    localparam logic [13:0] V_LPC  = 14'h0400;
    localparam logic [13:0] V_MRD  = 14'h0200;
    localparam logic [13:0] V_MWR  = 14'h0100;
    localparam logic [13:0] V_LRI  = 14'h0080;
    localparam logic [13:0] V_LAC  = 14'h0040;
    localparam logic [13:0] V_LNZ  = 14'h0020;
    localparam logic [13:0] V_HALT = 14'h0002;
    localparam logic [13:0] V_ILL  = 14'h0001;

    function automatic logic [13:0] v_ula(input logic [2:0] u);
        return {9'b0, u, 2'b0};
    endfunction

    logic       start_a, n_a, z_a, start_b, n_b, z_b;
    logic [3:0] opcode_a, opcode_b, dbg_a, dbg_b;
    logic       lrem_a, srem_a, inc_a, lpc_a, mrd_a, mwr_a, lri_a, lac_a, lnz_a, hlt_a, ill_a;
    logic       lrem_b, srem_b, inc_b, lpc_b, mrd_b, mwr_b, lri_b, lac_b, lnz_b, hlt_b, ill_b;
    logic [2:0] ula_a, ula_b;
    logic [13:0] obs_a, obs_b;

    assign obs_a = {lrem_a, srem_a, inc_a, lpc_a, mrd_a, mwr_a, lri_a, lac_a, lnz_a, ula_a, hlt_a, ill_a};
    assign obs_b = {lrem_b, srem_b, inc_b, lpc_b, mrd_b, mwr_b, lri_b, lac_b, lnz_b, ula_b, hlt_b, ill_b};

    neander_ctrl #(.MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .opcode(opcode_a), .n(n_a), .z(z_a),
        .load_rem(lrem_a), .sel_rem(srem_a), .inc_pc(inc_a), .load_pc(lpc_a),
        .mem_rd(mrd_a), .mem_wr(mwr_a), .load_ri(lri_a), .load_ac(lac_a),
        .load_nz(lnz_a), .ula_op(ula_a), .halted(hlt_a), .illegal(ill_a),
        .dbg_state(dbg_a)
    );

    neander_ctrl #(.MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .opcode(opcode_b), .n(n_b), .z(z_b),
        .load_rem(lrem_b), .sel_rem(srem_b), .inc_pc(inc_b), .load_pc(lpc_b),
        .mem_rd(mrd_b), .mem_wr(mwr_b), .load_ri(lri_b), .load_ac(lac_b),
        .load_nz(lnz_b), .ula_op(ula_b), .halted(hlt_b), .illegal(ill_b),
        .dbg_state(dbg_b)
    );

    // Scoreboard: expected vectors plus per-cycle drive info
    // drive code: 0 random inputs, 1 DEC cycle, 2 start held 0, 3 start=1
    logic [13:0] exp_q[$];
    logic [7:0]  drv_q[$];   // {code[1:0], op[3:0], n, z}
    logic [3:0]  cur_op;
    logic        cur_n, cur_z;
    int checks = 0;
    int fails  = 0;

    task automatic push(input logic [13:0] v, input logic [1:0] code);
        exp_q.push_back(v);
        drv_q.push_back({code, cur_op, cur_n, cur_z});
    endtask

    task automatic push_read(input int lat, input logic with_inc);
        for (int i = 0; i < lat; i++)
            push(V_MRD | ((with_inc && i == lat - 1) ? V_INC : 14'h0), 2'd0);
    endtask

    // Reference sequence of one instruction, from F0 up to (not including)
    // the next F0.
    task automatic build(input logic [3:0] op, input logic nn, input logic zz, input int lat);
        cur_op = op; cur_n = nn; cur_z = zz;
        push(V_LREM, 2'd0);
        push_read(lat, 1'b1);
        push(V_LRI, 2'd0);
        push(14'h0, 2'd1);
        case (op)
            4'h0: ;
            4'h6: push(v_ula(3'b100) | V_LAC | V_LNZ, 2'd0);
            4'hF: push(V_HALT, 2'd2);
            4'h8, 4'h9, 4'hA: begin
                if ((op == 4'h9 && !nn) || (op == 4'hA && !zz)) begin
                    push(V_INC, 2'd0);
                end else begin
                    push(V_LREM, 2'd0);
                    push_read(lat, 1'b1);
                    push(V_LPC, 2'd0);
                end
            end
            4'h1: begin
                push(V_LREM, 2'd0);
                push_read(lat, 1'b1);
                push(V_LREM | V_SREM, 2'd0);
                push(V_MWR, 2'd0);
            end
            4'h2, 4'h3, 4'h4, 4'h5: begin
                push(V_LREM, 2'd0);
                push_read(lat, 1'b1);
                push(V_LREM | V_SREM, 2'd0);
                push_read(lat, 1'b0);
                push(v_ula(3'(op - 4'h2)) | V_LAC | V_LNZ, 2'd0);
            end
            default: begin
`ifdef NEANDER_CTRL_ILLEGAL_TRAP_EN
                push(V_HALT | V_ILL, 2'd2);
`endif
            end
        endcase
    endtask

    // Runs cycles; entered and left #1 after a rising edge.
    task automatic run_cycles(input int which, input string name, input int count);
        logic [13:0] e, o;
        logic [7:0]  d;
        logic        s;
        for (int k = 0; k < count; k++) begin
            e = exp_q.pop_front();
            d = drv_q.pop_front();
            s = (d[7:6] == 2'd3) ? 1'b1 : (d[7:6] == 2'd2) ? 1'b0 : 1'($urandom_range(0, 1));
            if (which == 0) begin
                start_a  = s;
                opcode_a = (d[7:6] == 2'd1) ? d[5:2] : 4'($urandom_range(0, 15));
                n_a      = (d[7:6] == 2'd1) ? d[1] : 1'($urandom_range(0, 1));
                z_a      = (d[7:6] == 2'd1) ? d[0] : 1'($urandom_range(0, 1));
            end else begin
                start_b  = s;
                opcode_b = (d[7:6] == 2'd1) ? d[5:2] : 4'($urandom_range(0, 15));
                n_b      = (d[7:6] == 2'd1) ? d[1] : 1'($urandom_range(0, 1));
                z_b      = (d[7:6] == 2'd1) ? d[0] : 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            o = (which == 0) ? obs_a : obs_b;
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s cycle %0d: got %b expected %b", name, k, o, e);
            end
            @(posedge clk);
            #1;
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_all(input int which, input string name);
        run_cycles(which, name, exp_q.size());
    endtask

    task automatic do_reset;
        exp_q.delete();
        drv_q.delete();
        start_a = 1'b0; start_b = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic single(input int which, input string name, input logic [3:0] op,
                          input logic nn, input logic zz);
        int lat;
        lat = (which == 0) ? 1 : 3;
        do_reset();
        cur_op = 4'h0; cur_n = 1'b0; cur_z = 1'b0;
        push(14'h0, 2'd3);
        build(op, nn, zz, lat);
        push(V_LREM, 2'd0);
        run_all(which, name);
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (obs_a !== 14'h0) begin
            fails++;
            $display("FAIL reset_a: got %b expected 0", obs_a);
        end
        checks++;
        if (obs_b !== 14'h0) begin
            fails++;
            $display("FAIL reset_b: got %b expected 0", obs_b);
        end
        checks++;
        if (dbg_a !== 4'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d expected 0", dbg_a);
        end
    endtask

    task automatic test_nop;       single(0, "nop", 4'h0, 1'b0, 1'b0); endtask
    task automatic test_not;       single(0, "not", 4'h6, 1'b1, 1'b0); endtask
    task automatic test_sta;       single(0, "sta", 4'h1, 1'b0, 1'b1); endtask
    task automatic test_add_lat3;  single(1, "add_lat3", 4'h3, 1'b0, 1'b0); endtask

    task automatic test_alu;
        single(0, "lda", 4'h2, 1'b0, 1'b0);
        single(0, "add", 4'h3, 1'b1, 1'b1);
        single(0, "or",  4'h4, 1'b0, 1'b1);
        single(0, "and", 4'h5, 1'b1, 1'b0);
    endtask

    task automatic test_jumps;
        single(0, "jmp",      4'h8, 1'b0, 1'b0);
        single(0, "jz_skip",  4'hA, 1'b1, 1'b0);
        single(0, "jz_taken", 4'hA, 1'b0, 1'b1);
        single(0, "jn_skip",  4'h9, 1'b0, 1'b1);
        single(0, "jn_taken", 4'h9, 1'b1, 1'b0);
        single(1, "jz_lat3",  4'hA, 1'b0, 1'b1);
    endtask

    task automatic test_hlt;
        do_reset();
        cur_op = 4'h0; cur_n = 1'b0; cur_z = 1'b0;
        push(14'h0, 2'd3);
        build(4'hF, 1'b0, 1'b0, 1);
        push(V_HALT, 2'd2);
        push(V_HALT, 2'd3);
        push(V_LREM, 2'd0);
        run_all(0, "hlt");
    endtask

    task automatic test_illegal;
        do_reset();
        cur_op = 4'h0; cur_n = 1'b0; cur_z = 1'b0;
        push(14'h0, 2'd3);
        build(4'hC, 1'b0, 1'b0, 1);
`ifdef NEANDER_CTRL_ILLEGAL_TRAP_EN
        push(V_HALT | V_ILL, 2'd2);
        push(V_HALT | V_ILL, 2'd3);
`endif
        push(V_LREM, 2'd0);
        run_all(0, "illegal_1100");
    endtask

    task automatic test_back_to_back;
        logic [3:0] legal [10];
        legal = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA};
        for (int w = 0; w < 2; w++) begin
            do_reset();
            cur_op = 4'h0; cur_n = 1'b0; cur_z = 1'b0;
            push(14'h0, 2'd3);
            for (int i = 0; i < 12; i++)
                build(legal[$urandom_range(0, 9)], 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), (w == 0) ? 1 : 3);
            push(V_LREM, 2'd0);
            run_all(w, (w == 0) ? "b2b_lat1" : "b2b_lat3");
        end
    endtask

    task automatic test_rst_mid_b1;
        logic [13:0] e;
        do_reset();
        cur_op = 4'h0; cur_n = 1'b0; cur_z = 1'b0;
        push(14'h0, 2'd3);
        build(4'h2, 1'b0, 1'b0, 1);
        run_cycles(0, "rst_pre", 8);           // IDLE, F0..A2
        e = exp_q.pop_front();
        exp_q.delete();
        drv_q.delete();
        @(negedge clk);
        checks++;
        if (obs_a !== e) begin
            fails++;
            $display("FAIL rst_b1_entry: got %b expected %b", obs_a, e);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs_a !== 14'h0 || dbg_a !== 4'd0) begin
            fails++;
            $display("FAIL rst_async: got %b state %0d expected 0 state 0", obs_a, dbg_a);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_a !== 14'h0 || dbg_a !== 4'd0) begin
            fails++;
            $display("FAIL rst_release: got %b state %0d expected 0 state 0", obs_a, dbg_a);
        end
        @(posedge clk);
        #1;
        push(14'h0, 2'd3);
        push(V_LREM, 2'd0);
        run_all(0, "rst_restart");
    endtask

    initial begin
        start_a = 1'b0; opcode_a = 4'h0; n_a = 1'b0; z_a = 1'b0;
        start_b = 1'b0; opcode_b = 4'h0; n_b = 1'b0; z_b = 1'b0;
        test_reset();
        test_nop();
        test_not();
        test_jumps();
        test_sta();
        test_alu();
        test_add_lat3();
        test_hlt();
        test_illegal();
        test_back_to_back();
        test_rst_mid_b1();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
